// File: rtl/rpm_period_meter_pkg.sv
// Shared build constants and types for the tachometer period meter.
// The `define block is the project-wide configuration consumed by parameter defaults.
`ifndef RPM_CONFIG_DEFINED
`define RPM_CONFIG_DEFINED
`define RPM_WIDTH     14
`define RPM_PRESCALE  1000
`define RPM_DEBOUNCE  4
`define RPM_MAX_COUNT 9999
`define RPM_MIN_COUNT 1
`endif

package rpm_period_meter_pkg;

    typedef enum logic [0:0] {
        StWaitFirst,
        StMeasure
    } meter_state_e;

    // Width needed to hold values 0..n (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rpm_debounce.sv
// 2-FF synchroniser, run-length debounce filter and registered rising-edge pulse.
// Edge-to-pulse latency is a fixed 2 + DEBOUNCE + 1 cycles.
module rpm_debounce
    import rpm_period_meter_pkg::*;
#(
    parameter int unsigned DEBOUNCE = `RPM_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor,
    output logic rise
);

    localparam int unsigned RunW = cnt_width(DEBOUNCE);
    localparam logic [RunW-1:0] RunLast = RunW'(DEBOUNCE - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            level_dly_q;
    logic            rise_q;
    logic [RunW-1:0] run_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            run_q       <= '0;
        end else begin
            sync1_q     <= sensor;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            rise_q      <= level_q & ~level_dly_q;
            // Level flips on the cycle the disagreeing run reaches DEBOUNCE samples.
            if (sync2_q == level_q) begin
                run_q <= '0;
            end else if (run_q == RunLast) begin
                level_q <= sync2_q;
                run_q   <= '0;
            end else begin
                run_q <= run_q + 1'b1;
            end
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/rpm_period_meter.sv
// Tachometer period meter: counts prescaled ticks between debounced rising edges and
// publishes each interval with a toggle strobe; a stalled shaft publishes MAX_COUNT.
module rpm_period_meter
    import rpm_period_meter_pkg::*;
#(
    parameter int unsigned WIDTH     = `RPM_WIDTH,
    parameter int unsigned PRESCALE  = `RPM_PRESCALE,
    parameter int unsigned DEBOUNCE  = `RPM_DEBOUNCE,
    parameter int unsigned MAX_COUNT = `RPM_MAX_COUNT,
    parameter int unsigned MIN_COUNT = `RPM_MIN_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor,
    output logic [WIDTH-1:0] period,
    output logic             period_change,
    output logic             timeout
);

    localparam int unsigned PresW = cnt_width(PRESCALE - 1);
    localparam logic [PresW-1:0] PresLast = PresW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MaxCnt   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MaxM1    = WIDTH'(MAX_COUNT - 1);
    localparam logic [WIDTH-1:0] MinCnt   = WIDTH'(MIN_COUNT);

    meter_state_e     state_q, state_d;
    logic [PresW-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             change_q, change_d;
    logic             timeout_q, timeout_d;
    logic             rise;
    logic             tick;

    rpm_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .sensor (sensor),
        .rise   (rise)
    );

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        change_d  = change_q;
        timeout_d = timeout_q;
        tick      = 1'b0;
        unique case (state_q)
            StWaitFirst: begin
                presc_d = '0;
                cnt_d   = '0;
                if (rise) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                tick    = (presc_q == PresLast);
                presc_d = tick ? '0 : presc_q + 1'b1;
                // An accepted edge takes priority over a coincident tick, which is dropped.
                if (rise && (cnt_q >= MinCnt)) begin
                    period_d  = cnt_q;
                    change_d  = ~change_q;
                    timeout_d = 1'b0;
                    presc_d   = '0;
                    cnt_d     = '0;
                end else if (tick) begin
                    if (cnt_q >= MaxM1) begin
                        period_d  = MaxCnt;
                        change_d  = ~change_q;
                        timeout_d = 1'b1;
                        presc_d   = '0;
                        cnt_d     = '0;
                        state_d   = StWaitFirst;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StWaitFirst;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StWaitFirst;
            presc_q   <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            change_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            change_q  <= change_d;
            timeout_q <= timeout_d;
        end
    end

    assign period        = period_q;
    assign period_change = change_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_rpm_period_meter.sv
// Directed bench for rpm_period_meter with PRESCALE=4, DEBOUNCE=2, MAX_COUNT=20.
// Sensor edges are driven on the falling clock edge; interval N yields (N-1)/4 ticks.
module tb_rpm_period_meter;

    localparam int unsigned W = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         sensor;
    logic [W-1:0] period;
    logic         period_change;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int toggles  = 0;
    int base     = 0;

    rpm_period_meter #(
        .WIDTH     (W),
        .PRESCALE  (4),
        .DEBOUNCE  (2),
        .MAX_COUNT (20),
        .MIN_COUNT (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sensor        (sensor),
        .period        (period),
        .period_change (period_change),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    always @(period_change) begin
        if (rst === 1'b0) toggles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rise(input int high, input int gap);
        sensor = 1'b1;
        repeat (high) @(negedge clk);
        sensor = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic idle(input int n);
        sensor = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Checks published value, timeout flag and toggle count (strobe level follows its parity).
    task automatic check_pub(input string tag, input int p, input int t, input int n);
        check_eq({tag, "_period"}, 32'(period), 32'(p));
        check_eq({tag, "_timeout"}, 32'(timeout), 32'(t));
        check_eq({tag, "_toggles"}, 32'(toggles - base), 32'(n));
        check_eq({tag, "_change"}, 32'(period_change), 32'(n % 2));
    endtask

    initial begin
        rst    = 1'b1;
        sensor = 1'b0;
        repeat (3) @(negedge clk);
        check_pub("reset", 0, 0, 0);
        rst = 1'b0;
        idle(5);

        // Clean edges 42 cycles apart: first re-arms only.
        rise(10, 32);
        check_pub("arm", 0, 0, 0);
        rise(10, 32);
        check_pub("edge2", 10, 0, 1);
        // Third edge, then a 1-cycle glitch in the low phase.
        rise(10, 8);
        sensor = 1'b1;
        @(negedge clk);
        idle(2);
        idle(21);
        check_pub("glitch", 10, 0, 2);
        // Fourth edge carries a 1-cycle dropout while high.
        sensor = 1'b1;
        repeat (4) @(negedge clk);
        sensor = 1'b0;
        @(negedge clk);
        rise(5, 32);
        check_pub("dropout", 10, 0, 3);

        // Stall: no edge for 100 cycles.
        rise(10, 60);
        check_pub("pre_stall", 10, 0, 4);
        idle(40);
        check_pub("stall", 20, 1, 5);
        rise(4, 22);
        check_pub("rearm", 20, 1, 5);
        rise(10, 40);
        check_pub("after_stall", 6, 0, 6);
        idle(60);
        check_pub("stall2", 20, 1, 7);

        // Re-arm, then an edge 4 cycles later with count 0 is ignored.
        rise(2, 2);
        rise(2, 36);
        check_pub("min_ignored", 20, 1, 7);
        rise(10, 30);
        check_pub("min_next", 10, 0, 8);

        // 40-cycle interval: event coincides with the tenth tick, which is dropped.
        rise(10, 32);
        check_pub("wrap", 9, 0, 9);
        rise(10, 32);
        check_pub("wrap_restart", 10, 0, 10);
        rise(10, 32);
        check_pub("pre_reset", 10, 0, 11);

        // Asynchronous reset mid-pulse, off the clock edge.
        sensor = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_period", 32'(period), 32'd0);
        check_eq("async_rst_change", 32'(period_change), 32'd0);
        check_eq("async_rst_timeout", 32'(timeout), 32'd0);
        repeat (4) begin
            @(negedge clk);
            sensor = ~sensor;
        end
        sensor = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        base = toggles;
        idle(20);
        rise(10, 32);
        check_pub("post_rst_arm", 0, 0, 0);
        rise(10, 32);
        check_pub("post_rst_edge", 10, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
